// File: rtl/hazard3_instr_align_buf_pkg.sv
// Shared constants and helpers for the halfword instruction alignment buffer.
package hazard3_instr_align_buf_pkg;

   // Width of one buffered halfword.
   localparam int HW_W = 16;

   // Encodings of the cir_vld / cir_use halfword counts.
   localparam logic [1:0] HW_CNT_NONE = 2'd0;
   localparam logic [1:0] HW_CNT_ONE  = 2'd1;
   localparam logic [1:0] HW_CNT_TWO  = 2'd2;

   // Clamp a retire request to what cir actually holds, so an illegal
   // request can never pull garbage into the head of the buffer.
   function automatic logic [1:0] clamp_use(
      input logic [1:0] req,
      input logic [1:0] avail
   );
      logic [1:0] r;
      r = (req == 2'd3) ? HW_CNT_TWO : req;
      if (r > avail) begin
         return avail;
      end else begin
         return r;
      end
   endfunction

endpackage

// File: rtl/hazard3_instr_align_buf_chk.sv
// Protocol checker for the alignment buffer: decode must not retire more
// halfwords than cir presents, and the occupancy must stay in range.
module hazard3_instr_align_buf_chk #(
   parameter int DEPTH_HW = 6,
   parameter int W_LEVEL  = 3
) (
   input logic               clk,
   input logic               rst,
   input logic               jump_vld,
   input logic [1:0]         cir_use,
   input logic [1:0]         cir_vld,
   input logic [W_LEVEL-1:0] level
);

   // A jump discards cir_use, so the retire check only applies without one.
   a_use_le_vld : assert property (@(posedge clk) disable iff (rst)
      jump_vld || (cir_use <= cir_vld));

   // Occupancy never exceeds the buffer capacity.
   a_level_range : assert property (@(posedge clk) disable iff (rst)
      level <= W_LEVEL'(DEPTH_HW));

endmodule

// File: rtl/hazard3_instr_align_buf.sv
// Halfword-granular instruction alignment buffer. Word-aligned fetch data is
// split into halfwords held in a shift-down array (entry 0 is the oldest);
// decode sees the two oldest halfwords and retires 0, 1 or 2 per cycle.
module hazard3_instr_align_buf
   import hazard3_instr_align_buf_pkg::*;
#(
   parameter int DEPTH_HW = 6,
   parameter int W_LEVEL  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        fetch_data,
   input  logic               fetch_data_err,
   input  logic               fetch_data_vld,
   output logic               fetch_data_rdy,
   input  logic               jump_vld,
   input  logic               jump_target_hw,
   output logic [31:0]        cir,
   output logic [1:0]         cir_vld,
   output logic [1:0]         cir_err,
   input  logic [1:0]         cir_use,
   output logic [W_LEVEL-1:0] level
);

   logic [HW_W-1:0]    hw_buf_r [DEPTH_HW];
   logic [DEPTH_HW-1:0] err_r;
   logic [W_LEVEL-1:0] level_r;
   logic               discard_lo_r;

   // Buffer contents padded with two zero entries so every shift source is in range.
   logic [HW_W-1:0]     buf_ext_s [DEPTH_HW+2];
   logic [DEPTH_HW+1:0] err_ext_s;

   logic [HW_W-1:0]     buf_nxt_s [DEPTH_HW];
   logic [DEPTH_HW-1:0] err_nxt_s;

   logic               rdy_s;
   logic [1:0]         cir_vld_s;
   logic [1:0]         use_eff_s;
   logic               push_s;
   logic               push_two_s;
   logic [W_LEVEL-1:0] push_cnt_s;
   logic [W_LEVEL-1:0] base_s;
   logic [W_LEVEL-1:0] level_nxt_s;
   logic               discard_lo_nxt_s;
   logic [HW_W-1:0]    lane0_s;
   logic [HW_W-1:0]    lane1_s;

   generate
      for (genvar g = 0; g < DEPTH_HW + 2; g++) begin : g_ext
         if (g < DEPTH_HW) begin : g_live
            assign buf_ext_s[g] = hw_buf_r[g];
            assign err_ext_s[g] = err_r[g];
         end else begin : g_pad
            assign buf_ext_s[g] = {HW_W{1'b0}};
            assign err_ext_s[g] = 1'b0;
         end
      end
   endgenerate

   // Ready only from registered occupancy: room for a full word regardless of same-cycle pops.
   always_comb begin
      rdy_s = (level_r <= W_LEVEL'(DEPTH_HW - 2));
   end

   // Present the two oldest halfwords, masking entries at or above the level.
   always_comb begin
      cir     = 32'h0000_0000;
      cir_err = 2'b00;
      if (level_r >= W_LEVEL'(2)) begin
         cir_vld_s = HW_CNT_TWO;
      end else begin
         cir_vld_s = level_r[1:0];
      end
      if (level_r != W_LEVEL'(0)) begin
         cir[15:0]  = hw_buf_r[0];
         cir_err[0] = err_r[0];
      end else begin
         cir[15:0]  = 16'h0000;
         cir_err[0] = 1'b0;
      end
      if (level_r >= W_LEVEL'(2)) begin
         cir[31:16] = hw_buf_r[1];
         cir_err[1] = err_r[1];
      end else begin
         cir[31:16] = 16'h0000;
         cir_err[1] = 1'b0;
      end
   end

   // Decide how many halfwords leave and arrive this cycle, and where arrivals land.
   always_comb begin
      if (jump_vld) begin
         use_eff_s = HW_CNT_NONE;
      end else begin
         use_eff_s = clamp_use(cir_use, cir_vld_s);
      end
      push_s     = fetch_data_vld && rdy_s && !jump_vld;
      push_two_s = push_s && !discard_lo_r;
      if (!push_s) begin
         push_cnt_s = W_LEVEL'(0);
      end else if (discard_lo_r) begin
         push_cnt_s = W_LEVEL'(1);
      end else begin
         push_cnt_s = W_LEVEL'(2);
      end
      base_s = level_r - W_LEVEL'(use_eff_s);
      if (discard_lo_r) begin
         lane0_s = fetch_data[31:16];
      end else begin
         lane0_s = fetch_data[15:0];
      end
      lane1_s = fetch_data[31:16];
   end

   // Next occupancy and odd-halfword discard flag; a jump overrides pop and push.
   always_comb begin
      if (jump_vld) begin
         level_nxt_s      = W_LEVEL'(0);
         discard_lo_nxt_s = jump_target_hw;
      end else if (push_s) begin
         level_nxt_s      = base_s + push_cnt_s;
         discard_lo_nxt_s = 1'b0;
      end else begin
         level_nxt_s      = base_s;
         discard_lo_nxt_s = discard_lo_r;
      end
   end

   generate
      for (genvar g = 0; g < DEPTH_HW; g++) begin : g_entry
         logic [HW_W-1:0] shift_data_s;
         logic            shift_err_s;

         // Per-entry mux: hold, shift by one or two, or load from a push lane.
         always_comb begin
            case (use_eff_s)
               HW_CNT_NONE: begin
                  shift_data_s = buf_ext_s[g];
                  shift_err_s  = err_ext_s[g];
               end
               HW_CNT_ONE: begin
                  shift_data_s = buf_ext_s[g+1];
                  shift_err_s  = err_ext_s[g+1];
               end
               HW_CNT_TWO: begin
                  shift_data_s = buf_ext_s[g+2];
                  shift_err_s  = err_ext_s[g+2];
               end
               default: begin
                  shift_data_s = buf_ext_s[g];
                  shift_err_s  = err_ext_s[g];
               end
            endcase
            if (push_s && (base_s == W_LEVEL'(g))) begin
               buf_nxt_s[g] = lane0_s;
               err_nxt_s[g] = fetch_data_err;
            end else if (push_two_s && ((base_s + W_LEVEL'(1)) == W_LEVEL'(g))) begin
               buf_nxt_s[g] = lane1_s;
               err_nxt_s[g] = fetch_data_err;
            end else begin
               buf_nxt_s[g] = shift_data_s;
               err_nxt_s[g] = shift_err_s;
            end
         end
      end
   endgenerate

   // State update; reset clears everything and wins over jump, push and pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_r      <= W_LEVEL'(0);
         discard_lo_r <= 1'b0;
         err_r        <= {DEPTH_HW{1'b0}};
         for (int i = 0; i < DEPTH_HW; i++) begin
            hw_buf_r[i] <= {HW_W{1'b0}};
         end
      end else begin
         level_r      <= level_nxt_s;
         discard_lo_r <= discard_lo_nxt_s;
         err_r        <= err_nxt_s;
         for (int i = 0; i < DEPTH_HW; i++) begin
            hw_buf_r[i] <= buf_nxt_s[i];
         end
      end
   end

   assign fetch_data_rdy = rdy_s;
   assign cir_vld        = cir_vld_s;
   assign level          = level_r;

   hazard3_instr_align_buf_chk #(
      .DEPTH_HW (DEPTH_HW),
      .W_LEVEL  (W_LEVEL)
   ) u_chk (
      .clk      (clk),
      .rst      (rst),
      .jump_vld (jump_vld),
      .cir_use  (cir_use),
      .cir_vld  (cir_vld_s),
      .level    (level_r)
   );

endmodule
